spi_master: RTL and testbench

Single-byte SPI mode-0 master (CPOL=0, CPHA=0) that drives the chip-select, clock and MOSI lines of our SPI slave and captures its MISO response. It sits between the on-chip controller (start/data handshake) and the SPI pins, and runs in the same system clock domain as the slave. Each accepted request produces one 8-bit full-duplex transfer, MSB first, framed by chip-select.

---
 rtl/spi_master_if.sv | 24 ++
 rtl/spi_master.sv | 141 ++++++++++++++
 tb/tb_spi_master.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Controller-side handshake and SPI pin bundle for spi_master.
// The master modport is the view taken by spi_master itself; the slave
// modport is the view taken by whatever drives requests and models MISO.
interface spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  modport master (
    input  start, tx_data, spi_miso,
    output busy, done, rx_data, spi_clk, spi_mosi, spi_cs_n
  );

  modport slave (
    output start, tx_data, spi_miso,
    input  busy, done, rx_data, spi_clk, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI mode-0 master (CPOL=0, CPHA=0), MSB first, full duplex.
// One accepted start produces SETUP, 16 clock toggles, HOLD and a CS-high GAP.
module spi_master #(
  parameter int CLK_DIV = 4  // system clocks per SPI half-period, 2..255
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] TC_VAL = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       tc;

  // Next-state and output computation for the transfer sequencer
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    tc = (cnt_q == TC_VAL);
    // Half-period counter idles at 0 and wraps on every terminal count,
    // which is also the only point where a state change happens.
    cnt_d = (state_q == IDLE || tc) ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_d    = bus.tx_data;
          rx_sh_d = 8'd0;
          bit_d   = 4'd0;
          cs_n_d  = 1'b0;
          mosi_d  = bus.tx_data[7];
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // The end of the setup half-period is also the first rising edge,
        // so capture bit 7 of MISO here and continue in SHIFT.
        if (tc) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], bus.spi_miso};
          bit_d   = bit_q + 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tc) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[6:0], bus.spi_miso};
            bit_d   = bit_q + 4'd1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd8) begin
              mosi_d  = 1'b0;
              state_d = HOLD;
            end else begin
              // tx_q[6] is always the next bit to present after a falling edge
              mosi_d = tx_q[6];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (tc) begin
          cs_n_d    = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tc) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 4'd0;
      tx_q      <= 8'd0;
      rx_sh_q   <= 8'd0;
      rx_data_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.spi_clk  = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=2) checked every
// cycle against a timing model derived from elapsed cycles since acceptance.
module tb_spi_master;

  localparam int N   = 2;
  localparam int CD0 = 4;
  localparam int CD1 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_v [N];
  logic [7:0] tx_v    [N];
  logic       miso_v  [N];
  bit         loop_v  [N];

  wire       busy_w [N];
  wire       done_w [N];
  wire       sclk_w [N];
  wire       mosi_w [N];
  wire       cs_w   [N];
  wire [7:0] rx_w   [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      spi_master_if bus ();
      assign bus.start    = start_v[gi];
      assign bus.tx_data  = tx_v[gi];
      assign bus.spi_miso = miso_v[gi];
      assign busy_w[gi]   = bus.busy;
      assign done_w[gi]   = bus.done;
      assign sclk_w[gi]   = bus.spi_clk;
      assign mosi_w[gi]   = bus.spi_mosi;
      assign cs_w[gi]     = bus.spi_cs_n;
      assign rx_w[gi]     = bus.rx_data;

      spi_master #(.CLK_DIV((gi == 0) ? CD0 : CD1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
      );
    end
  endgenerate

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cdv(input int i);
    return (i == 0) ? CD0 : CD1;
  endfunction

  // ---------------- reference model ----------------
  int       cyc = 0;
  bit       act     [N];
  int       e0      [N];
  int       free_at [N];
  bit [7:0] txe     [N];
  bit [7:0] slv     [N];
  bit [7:0] rxp     [N];
  bit       lpe     [N];
  int       tog     [N];
  bit       sclk_p  [N];
  int       ndone   [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance: a start is taken when the previous transfer has fully ended
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        act[i]     <= 1'b0;
        free_at[i] <= 0;
        rxp[i]     <= 8'd0;
      end else if (start_v[i] && cyc >= free_at[i]) begin
        act[i]     <= 1'b1;
        e0[i]      <= cyc;
        free_at[i] <= cyc + 18 * cdv(i) + 1;
        txe[i]     <= tx_v[i];
        lpe[i]     <= loop_v[i];
        slv[i]     <= loop_v[i] ? tx_v[i] : 8'($urandom);
        rxp[i]     <= act[i] ? slv[i] : rxp[i];
      end
    end
  end

  // Per-cycle comparison of every output, plus the slave MISO driver
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int d, rel, bi;
      bit x;
      logic e_mosi, e_miso;
      logic [7:0] e_rx;
      d   = cdv(i);
      rel = cyc - e0[i] - 1;
      x   = act[i];
      bi  = 7 - rel / (2 * d);
      e_mosi = (x && rel < 16 * d) ? txe[i][bi[2:0]] : 1'b0;
      e_rx   = (x && rel >= 17 * d) ? slv[i] : rxp[i];
      check_val($sformatf("u%0d.busy", i), 32'(busy_w[i]), 32'(x && rel < 18 * d));
      check_val($sformatf("u%0d.cs_n", i), 32'(cs_w[i]), 32'(!(x && rel < 17 * d)));
      check_val($sformatf("u%0d.done", i), 32'(done_w[i]), 32'(x && rel == 17 * d));
      check_val($sformatf("u%0d.sclk", i), 32'(sclk_w[i]),
                32'(x && rel < 16 * d && ((rel / d) % 2 == 1)));
      check_val($sformatf("u%0d.mosi", i), 32'(mosi_w[i]), 32'(e_mosi));
      check_val($sformatf("u%0d.rx_data", i), 32'(rx_w[i]), 32'(e_rx));
      if (done_w[i]) begin
        check_val($sformatf("u%0d.toggles", i), 32'(tog[i]), 32'd16);
        $display("u%0d xfer tx=%02h slave=%02h rx=%02h rel=%0d", i, txe[i], slv[i], rx_w[i], rel);
        ndone[i] <= ndone[i] + 1;
      end
      tog[i]    <= (x && rel == 0) ? 0 : tog[i] + ((sclk_w[i] !== sclk_p[i]) ? 1 : 0);
      sclk_p[i] <= sclk_w[i];
      e_miso = (x && rel < 16 * d) ? slv[i][bi[2:0]] : 1'b0;
      miso_v[i] <= lpe[i] ? mosi_w[i] : e_miso;
    end
  end

  task automatic wait_done(input int i, input int max_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(posedge clk); #2;
      if (done_w[i]) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_idle(input int i, input string tag);
    check_val($sformatf("u%0d.%s_cs_n", i, tag), 32'(cs_w[i]), 32'd1);
    check_val($sformatf("u%0d.%s_sclk", i, tag), 32'(sclk_w[i]), 32'd0);
    check_val($sformatf("u%0d.%s_mosi", i, tag), 32'(mosi_w[i]), 32'd0);
    check_val($sformatf("u%0d.%s_busy", i, tag), 32'(busy_w[i]), 32'd0);
    check_val($sformatf("u%0d.%s_done", i, tag), 32'(done_w[i]), 32'd0);
    check_val($sformatf("u%0d.%s_rx", i, tag), 32'(rx_w[i]), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nd;
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0;
      tx_v[i]    = 8'd0;
      loop_v[i]  = 1'b0;
      miso_v[i]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) check_idle(i, "reset");
    rst_n = 1'b1;

    // Loopback 0xA5 on the CLK_DIV=4 instance
    loop_v[0] = 1'b1; tx_v[0] = 8'hA5; start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0; tx_v[0] = 8'h00; loop_v[0] = 1'b0;
    wait_done(0, 40 * CD0, "u0.a5_done");
    check_val("u0.a5_rx", 32'(rx_w[0]), 32'hA5);

    // start held high on the CLK_DIV=2 instance: back-to-back transfers
    nd = ndone[1];
    start_v[1] = 1'b1;
    for (int k = 0; k < 3 * (18 * CD1 + 1) + 4; k++) begin
      tx_v[1] = 8'($urandom);
      @(posedge clk); #2;
    end
    start_v[1] = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check_val("u1.held_xfers", 32'(ndone[1] - nd), 32'd4);

    // Randomised requests, including starts while busy and changing tx_data
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        start_v[i] = ($urandom_range(0, 7) == 0);
        tx_v[i]    = 8'($urandom);
        loop_v[i]  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #2;
    end
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0;
      loop_v[i]  = 1'b0;
    end
    repeat (100) @(posedge clk);
    #2;

    // Reset just after the third rising toggle, then a fresh transfer
    tx_v[0] = 8'h5A; start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0;
    repeat (5 * CD0) @(posedge clk);
    #2;
    check_val("u0.pre_rst_sclk", 32'(sclk_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check_idle(i, "midrst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    loop_v[0] = 1'b1; tx_v[0] = 8'h81; start_v[0] = 1'b1;
    @(posedge clk); #2;
    start_v[0] = 1'b0; loop_v[0] = 1'b0;
    wait_done(0, 40 * CD0, "u0.x81_done");
    check_val("u0.x81_rx", 32'(rx_w[0]), 32'h81);
    repeat (20) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
